// File: rtl/hi_lo_unit.sv
// hi_lo_unit: architectural HI/LO register pair with a multi-cycle restoring divider.
// Ports:
//   Clk, Rst              - clock, synchronous active-high reset
//   HiLoEn, HiLoWrite     - ALU write of {HI,LO} (MULT/MULTU/MADD/MSUB)
//   MthiEn, MtloEn        - MTHI/MTLO strobes, data from MoveData
//   DivStart, DivSigned   - divide request (accepted only when idle), DIV vs DIVU
//   DivA, DivB            - dividend / divisor, sampled with DivStart
//   HiLoRead              - current {HI,LO}, straight from registers
//   Busy                  - divider active
//   DivDone, DivByZero    - one-cycle completion pulse and divide-by-zero flag
module hi_lo_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        HiLoEn,
  input  logic [63:0] HiLoWrite,
  input  logic        MthiEn,
  input  logic        MtloEn,
  input  logic [31:0] MoveData,
  input  logic        DivStart,
  input  logic        DivSigned,
  input  logic [31:0] DivA,
  input  logic [31:0] DivB,
  output logic [63:0] HiLoRead,
  output logic        Busy,
  output logic        DivDone,
  output logic        DivByZero
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     hi_q, hi_d;
  logic [DW-1:0]     lo_q, lo_d;
  logic              sgn_q, sgn_d;
  logic [DW-1:0]     a_q, a_d;     // raw dividend, kept for the divide-by-zero result
  logic [DW-1:0]     b_q, b_d;     // raw divisor, then |B| after PREP
  logic [DW-1:0]     rem_q, rem_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic [DW:0]       shifted;
  logic [DW-1:0]     trial;
  logic              fits;

  // State and register update
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next state; register writes applied lowest priority first so later ones win
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    // One restoring step: shift {rem,quo} left and try subtracting |B|
    shifted = {rem_q, quo_q[DW-1]};
    fits    = (shifted >= {1'b0, b_q});
    trial   = shifted[DW-1:0] - b_q;

    if (MthiEn) hi_d = MoveData;
    if (MtloEn) lo_d = MoveData;
    if (HiLoEn) begin
      hi_d = HiLoWrite[63:32];
      lo_d = HiLoWrite[31:0];
    end

    case (state_q)
      S_IDLE: begin
        if (DivStart) begin
          sgn_d   = DivSigned;
          a_d     = DivA;
          b_d     = DivB;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d   = (sgn_q && a_q[DW-1]) ? (~a_q + DW'(1)) : a_q;
        b_d     = (sgn_q && b_q[DW-1]) ? (~b_q + DW'(1)) : b_q;
        qneg_d  = sgn_q & (a_q[DW-1] ^ b_q[DW-1]);
        rneg_d  = sgn_q & a_q[DW-1];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = fits ? trial : shifted[DW-1:0];
        quo_d = {quo_q[DW-2:0], fits};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Divide by zero bypasses sign correction and reports the raw dividend
        if (b_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rneg_q ? (~rem_q + DW'(1)) : rem_q;
          lo_d = qneg_q ? (~quo_q + DW'(1)) : quo_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign HiLoRead  = {hi_q, lo_q};
  assign Busy      = (state_q != S_IDLE);
  assign DivDone   = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit: self-checking bench for hi_lo_unit; divide results go through a scoreboard queue.
module tb_hi_lo_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic        MthiEn;
  logic        MtloEn;
  logic [31:0] MoveData;
  logic        DivStart;
  logic        DivSigned;
  logic [31:0] DivA;
  logic [31:0] DivB;
  logic [63:0] HiLoRead;
  logic        Busy;
  logic        DivDone;
  logic        DivByZero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] hilo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  hi_lo_unit #(.DIV_CYCLES(32)) dut (
    .Clk(Clk), .Rst(Rst), .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite),
    .MthiEn(MthiEn), .MtloEn(MtloEn), .MoveData(MoveData),
    .DivStart(DivStart), .DivSigned(DivSigned), .DivA(DivA), .DivB(DivB),
    .HiLoRead(HiLoRead), .Busy(Busy), .DivDone(DivDone), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  // Reference divide using language arithmetic plus the two defined corner cases
  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Starts a divide at the current negedge and waits (bounded) for DivDone.
  // hit_kind 1: extra DivStart at cycle hit_cyc; 2: HiLoEn write at cycle hit_cyc.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hit_cyc, input int hit_kind,
                         output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    DivStart = 1'b1; DivSigned = sgn; DivA = a; DivB = b;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge Clk);
      DivStart = 1'b0;
      HiLoEn   = 1'b0;
      if (Busy) busy_n++;
      if (DivDone) lat = c;
      if (c == hit_cyc && hit_kind == 1) begin
        DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd999; DivB = 32'd3;
      end
      if (c == hit_cyc && hit_kind == 2) begin
        HiLoEn = 1'b1; HiLoWrite = 64'h5555_5555_AAAA_AAAA;
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    total++; if (HiLoRead !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h want %h", HiLoRead, 64'd0); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (DivDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", DivDone); end
    total++; if (DivByZero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
  endtask

  task automatic test_hilo_write();
    HiLoEn = 1'b1; HiLoWrite = 64'h0000_0001_FFFF_FFFE;
    @(negedge Clk);
    HiLoEn = 1'b0;
    total++; if (HiLoRead !== 64'h0000_0001_FFFF_FFFE) begin bad++; $display("FAIL hilo_write: got %h want %h", HiLoRead, 64'h0000_0001_FFFF_FFFE); end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    total++; if (HiLoRead !== 64'd0) begin bad++; $display("FAIL hilo_reset: got %h want %h", HiLoRead, 64'd0); end
  endtask

  task automatic test_move();
    HiLoEn = 1'b1; HiLoWrite = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge Clk);
    HiLoEn = 1'b0; MthiEn = 1'b1; MoveData = 32'hDEAD_BEEF;
    @(negedge Clk);
    MthiEn = 1'b0;
    total++; if (HiLoRead !== 64'hDEAD_BEEF_CCCC_DDDD) begin bad++; $display("FAIL mthi: got %h want %h", HiLoRead, 64'hDEAD_BEEF_CCCC_DDDD); end
    MtloEn = 1'b1; MoveData = 32'h0123_4567;
    @(negedge Clk);
    MtloEn = 1'b0;
    total++; if (HiLoRead !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL mtlo: got %h want %h", HiLoRead, 64'hDEAD_BEEF_0123_4567); end
    MthiEn = 1'b1; MtloEn = 1'b1; MoveData = 32'h0F0F_0F0F;
    @(negedge Clk);
    MthiEn = 1'b0; MtloEn = 1'b0;
    total++; if (HiLoRead !== 64'h0F0F_0F0F_0F0F_0F0F) begin bad++; $display("FAIL mthi_mtlo: got %h want %h", HiLoRead, 64'h0F0F_0F0F_0F0F_0F0F); end
    HiLoEn = 1'b1; HiLoWrite = 64'h1234; MthiEn = 1'b1; MoveData = 32'hDEAD_BEEF;
    @(negedge Clk);
    HiLoEn = 1'b0; MthiEn = 1'b0;
    total++; if (HiLoRead !== 64'h1234) begin bad++; $display("FAIL hiloen_over_mthi: got %h want %h", HiLoRead, 64'h1234); end
  endtask

  task automatic test_divu();
    int lat, busy_n;
    exp_t e;
    sb.push_back('{hilo: {32'd2, 32'd14}, dbz: 1'b0});
    run_div(1'b0, 32'd100, 32'd7, 10, 1, lat, busy_n);
    total++; if (lat !== 35) begin bad++; $display("FAIL divu_latency: got %0d want 35", lat); end
    total++; if (busy_n !== 34) begin bad++; $display("FAIL divu_busy_cycles: got %0d want 34", busy_n); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL divu_result: got %h want %h", HiLoRead, e.hilo); end
      total++; if (DivByZero !== e.dbz) begin bad++; $display("FAIL divu_dbz: got %b want %b", DivByZero, e.dbz); end
    end
    @(negedge Clk);
    total++; if (DivDone !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL divu_done_pulse: got done=%b busy=%b want done=0 busy=0", DivDone, Busy); end
  endtask

  task automatic test_div_signed();
    logic [31:0] ta[9], tb_[9];
    logic        ts[9];
    int lat, busy_n;
    exp_t e;
    ts[0] = 1'b1; ta[0] = 32'hFFFF_FFF9; tb_[0] = 32'd2;
    ts[1] = 1'b1; ta[1] = 32'h8000_0000; tb_[1] = 32'hFFFF_FFFF;
    ts[2] = 1'b1; ta[2] = 32'd100;       tb_[2] = 32'hFFFF_FFF9;
    ts[3] = 1'b1; ta[3] = 32'hFFFF_FF9C; tb_[3] = 32'hFFFF_FFF9;
    ts[4] = 1'b0; ta[4] = 32'hFFFF_FFFF; tb_[4] = 32'd10;
    for (int i = 5; i < 9; i++) begin
      ts[i] = 1'($urandom_range(1, 0));
      ta[i] = $urandom;
      tb_[i] = $urandom | 32'd1;
    end
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: sb.push_back('{hilo: {32'hFFFF_FFFF, 32'hFFFF_FFFD}, dbz: 1'b0});
        1: sb.push_back('{hilo: {32'h0000_0000, 32'h8000_0000}, dbz: 1'b0});
        2: sb.push_back('{hilo: {32'd2, 32'hFFFF_FFF2}, dbz: 1'b0});
        3: sb.push_back('{hilo: {32'hFFFF_FFFE, 32'd14}, dbz: 1'b0});
        4: sb.push_back('{hilo: {32'd5, 32'h1999_9999}, dbz: 1'b0});
        default: sb.push_back('{hilo: model_div(ts[i], ta[i], tb_[i]), dbz: 1'b0});
      endcase
      run_div(ts[i], ta[i], tb_[i], 0, 0, lat, busy_n);
      total++; if (lat !== 35) begin bad++; $display("FAIL div_%0d_latency: got %0d want 35", i, lat); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL div_%0d_result a=%h b=%h s=%b: got %h want %h", i, ta[i], tb_[i], ts[i], HiLoRead, e.hilo); end
        total++; if (DivByZero !== e.dbz) begin bad++; $display("FAIL div_%0d_dbz: got %b want %b", i, DivByZero, e.dbz); end
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, busy_n;
    exp_t e;
    sb.push_back('{hilo: {32'd55, 32'hFFFF_FFFF}, dbz: 1'b1});
    run_div(1'b0, 32'd55, 32'd0, 5, 2, lat, busy_n);
    total++; if (lat !== 35) begin bad++; $display("FAIL dbz_latency: got %0d want 35", lat); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL dbz_result: got %h want %h", HiLoRead, e.hilo); end
      total++; if (DivByZero !== e.dbz) begin bad++; $display("FAIL dbz_flag: got %b want %b", DivByZero, e.dbz); end
    end
    sb.push_back('{hilo: {32'hFFFF_FFFB, 32'hFFFF_FFFF}, dbz: 1'b1});
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 0, lat, busy_n);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL dbz_signed_result: got %h want %h", HiLoRead, e.hilo); end
      total++; if (DivByZero !== e.dbz) begin bad++; $display("FAIL dbz_signed_flag: got %b want %b", DivByZero, e.dbz); end
    end
  endtask

  task automatic test_abort();
    int done_seen;
    int lat, busy_n;
    exp_t e;
    HiLoEn = 1'b1; HiLoWrite = 64'h1111_2222_3333_4444;
    @(negedge Clk);
    HiLoEn = 1'b0;
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd200; DivB = 32'd3;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      DivStart = 1'b0;
    end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
    total++; if (HiLoRead !== 64'd0) begin bad++; $display("FAIL abort_hilo: got %h want %h", HiLoRead, 64'd0); end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (DivDone) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
    sb.push_back('{hilo: {32'd0, 32'd100}, dbz: 1'b0});
    run_div(1'b0, 32'd1000, 32'd10, 0, 0, lat, busy_n);
    total++; if (lat !== 35) begin bad++; $display("FAIL abort_restart_latency: got %0d want 35", lat); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL abort_restart_result: got %h want %h", HiLoRead, e.hilo); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    exp_t e;
    sb.push_back('{hilo: {32'd3, 32'd33}, dbz: 1'b0});
    run_div(1'b0, 32'd300, 32'd9, 0, 0, lat, busy_n);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL b2b_first_result: got %h want %h", HiLoRead, e.hilo); end
    end
    // Start issued in the DivDone cycle must be accepted
    sb.push_back('{hilo: {32'd0, 32'd1}, dbz: 1'b0});
    run_div(1'b0, 32'd7, 32'd7, 0, 0, lat, busy_n);
    total++; if (lat !== 35) begin bad++; $display("FAIL b2b_second_latency: got %0d want 35", lat); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (HiLoRead !== e.hilo) begin bad++; $display("FAIL b2b_second_result: got %h want %h", HiLoRead, e.hilo); end
    end
  endtask

  initial begin
    Rst = 1'b1; HiLoEn = 1'b0; HiLoWrite = '0; MthiEn = 1'b0; MtloEn = 1'b0;
    MoveData = '0; DivStart = 1'b0; DivSigned = 1'b0; DivA = '0; DivB = '0;
    @(negedge Clk);
    test_reset();
    test_hilo_write();
    test_move();
    test_divu();
    test_div_signed();
    test_div_by_zero();
    test_abort();
    test_back_to_back();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
